// File: rtl/spike_frame_extractor.sv
// spike_frame_extractor
//   Captures a fixed-length window of samples around each detected spike.
//   Samples are written into a FRAME-deep ring buffer. A spike is a sample
//   whose absolute deviation from mid-scale exceeds THRESHOLD. Once a spike
//   is seen, POST samples are collected, counting the spike as the first.
//   The whole frame is then streamed out oldest-first over a valid/ready
//   handshake.
//
// State table
//   state   | meaning
//   IDLE    | block disabled, nothing written
//   FILL    | priming ring buffer with PRE fresh samples, trigger ignored
//   ARMED   | writing samples, watching for a spike
//   CAPTURE | spike seen, collecting the remaining POST-1 samples
//   SEND    | streaming FRAME beats, incoming samples dropped
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   EN              block enable; low forces IDLE and abandons any frame
//   DATA_IN         offset-binary sample, qualified by DATA_VALID_IN
//   THRESHOLD       unsigned threshold on |DATA_IN - MID|
//   FRAME_DATA      frame beat, oldest sample first
//   FRAME_VALID     FRAME_DATA valid; FRAME_READY accepts the beat
//   FRAME_LAST      marks the final beat of a frame
//   BUSY            high in CAPTURE or SEND
//   FRAME_CNT       completed frames, wraps
//   DROPPED         samples discarded during SEND, saturates
//
// PRE >= 1 and POST >= 1 are assumed, and PRE+POST must be a power of two.
module spike_frame_extractor #(
  parameter int BITSIZE = 16,
  parameter int PRE     = 8,
  parameter int POST    = 24
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [BITSIZE-1:0] DATA_IN,
  input  logic               DATA_VALID_IN,
  input  logic [BITSIZE-2:0] THRESHOLD,
  output logic [BITSIZE-1:0] FRAME_DATA,
  output logic               FRAME_VALID,
  input  logic               FRAME_READY,
  output logic               FRAME_LAST,
  output logic               BUSY,
  output logic [15:0]        FRAME_CNT,
  output logic [7:0]         DROPPED
);

  localparam int FRAME = PRE + POST;
  localparam int AW    = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int CW    = AW + 1;

  localparam logic [CW-1:0] PRE_M1   = CW'(PRE - 1);
  localparam logic [CW-1:0] POST_M1  = CW'(POST - 1);
  localparam logic [CW-1:0] FRAME_N  = CW'(FRAME);
  localparam logic [CW-1:0] FRAME_M1 = CW'(FRAME - 1);

  // Mid-scale at BITSIZE+1 bits, so the deviation of an all-zero sample
  // (exactly 2^(BITSIZE-1)) is representable.
  localparam logic [BITSIZE:0] MID = {2'b01, {(BITSIZE-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ARMED,
    S_CAPTURE,
    S_SEND
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [BITSIZE-1:0] r_mem [FRAME];
  logic [AW-1:0]      r_wr_ptr;
  logic [CW-1:0]      r_fill_cnt;
  logic [CW-1:0]      r_post_rem;
  logic [CW-1:0]      r_beat_cnt;
  logic [BITSIZE-1:0] r_frame_data;
  logic               r_valid;
  logic               r_last;
  logic [15:0]        r_frame_cnt;
  logic [7:0]         r_dropped;

  logic [BITSIZE:0]   w_sample_ext;
  logic [BITSIZE:0]   w_dev;
  logic               w_trig;
  logic               w_wr;
  logic               w_load;
  logic               w_accept;
  logic               w_frame_done;
  logic [AW-1:0]      w_rd_addr;

  // Absolute deviation from mid-scale
  assign w_sample_ext = {1'b0, DATA_IN};
  assign w_dev        = (w_sample_ext >= MID) ? (w_sample_ext - MID) : (MID - w_sample_ext);
  assign w_trig       = (w_dev > {2'b00, THRESHOLD});

  assign w_wr = EN && DATA_VALID_IN &&
                ((r_state == S_FILL) || (r_state == S_ARMED) || (r_state == S_CAPTURE));

  // When SEND is entered the write pointer sits on the oldest sample, so
  // beat n lives at wr_ptr + n. The ring wraps naturally at FRAME = 2^AW.
  assign w_rd_addr    = r_wr_ptr + r_beat_cnt[AW-1:0];
  assign w_accept     = r_valid && FRAME_READY;
  assign w_frame_done = (r_state == S_SEND) && w_accept && r_last;
  // Refill the output register when it is empty or being drained this cycle
  assign w_load       = (r_state == S_SEND) && EN && (r_beat_cnt != FRAME_N) &&
                        (!r_valid || FRAME_READY);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!EN) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_FILL;
        S_FILL:    if (w_wr && (r_fill_cnt == PRE_M1)) w_state_nxt = S_ARMED;
        S_ARMED: begin
          if (w_wr && w_trig) begin
            if (POST == 1) w_state_nxt = S_SEND;
            else           w_state_nxt = S_CAPTURE;
          end
        end
        S_CAPTURE: if (w_wr && (r_post_rem == CW'(1))) w_state_nxt = S_SEND;
        S_SEND:    if (w_frame_done) w_state_nxt = S_FILL;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Sample storage carries no reset; every entry is rewritten before it
  // can be read out.
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= DATA_IN;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr     <= '0;
      r_fill_cnt   <= '0;
      r_post_rem   <= '0;
      r_beat_cnt   <= '0;
      r_frame_data <= '0;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_frame_cnt  <= '0;
      r_dropped    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);

      // Clearing outside FILL gives a zeroed counter on every FILL entry
      if (r_state != S_FILL)  r_fill_cnt <= '0;
      else if (w_wr)          r_fill_cnt <= r_fill_cnt + CW'(1);

      // Down-counter of samples still owed after the trigger sample
      if ((r_state == S_ARMED) && w_wr && w_trig) r_post_rem <= POST_M1;
      else if ((r_state == S_CAPTURE) && w_wr)    r_post_rem <= r_post_rem - CW'(1);

      if (r_state != S_SEND)  r_beat_cnt <= '0;
      else if (w_load)        r_beat_cnt <= r_beat_cnt + CW'(1);

      if (!EN || (r_state != S_SEND)) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else if (w_load) begin
        r_frame_data <= r_mem[w_rd_addr];
        r_valid      <= 1'b1;
        r_last       <= (r_beat_cnt == FRAME_M1);
      end else if (w_accept) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end

      if (EN && w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;

      if ((r_state == S_SEND) && DATA_VALID_IN && (r_dropped != 8'hFF))
        r_dropped <= r_dropped + 8'd1;
    end
  end

  assign FRAME_DATA  = r_frame_data;
  assign FRAME_VALID = r_valid;
  assign FRAME_LAST  = r_last;
  assign BUSY        = (r_state == S_CAPTURE) || (r_state == S_SEND);
  assign FRAME_CNT   = r_frame_cnt;
  assign DROPPED     = r_dropped;

endmodule

// File: tb/tb_spike_frame_extractor.sv
module tb_spike_frame_extractor;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EN = 1'b0;
  logic [15:0] DATA_IN = 16'h8000;
  logic        DATA_VALID_IN = 1'b0;
  logic [14:0] THRESHOLD = 15'd1000;
  logic [15:0] FRAME_DATA;
  logic        FRAME_VALID;
  logic        FRAME_READY = 1'b1;
  logic        FRAME_LAST;
  logic        BUSY;
  logic [15:0] FRAME_CNT;
  logic [7:0]  DROPPED;

  spike_frame_extractor #(.BITSIZE(16), .PRE(8), .POST(24)) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .DATA_IN(DATA_IN), .DATA_VALID_IN(DATA_VALID_IN), .THRESHOLD(THRESHOLD),
    .FRAME_DATA(FRAME_DATA), .FRAME_VALID(FRAME_VALID), .FRAME_READY(FRAME_READY),
    .FRAME_LAST(FRAME_LAST), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT), .DROPPED(DROPPED)
  );

  always #5 CLK = ~CLK;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int first_valid = -1;
  int last_dv = -1;
  int rdy_mode = 0;      // 0: always ready, 1: toggle each cycle, 2: never
  int stall_viol = 0;
  int stall_seen = 0;
  logic        p_stall = 1'b0;
  logic [15:0] p_data = '0;
  logic        p_last = 1'b0;
  logic [15:0] bq[$];
  logic        lq[$];

  // One cycle: observe outputs at the falling edge, then drive the inputs
  // for the next rising edge and record any beat that edge will accept.
  task automatic step(input logic dv, input logic [15:0] d);
    logic rdy;
    @(negedge CLK);
    cyc++;
    if (p_stall) begin
      stall_seen++;
      if (FRAME_VALID !== 1'b1 || FRAME_DATA !== p_data || FRAME_LAST !== p_last) stall_viol++;
    end
    if (FRAME_VALID === 1'b1 && first_valid < 0) first_valid = cyc;
    rdy = (rdy_mode == 0) ? 1'b1 : ((rdy_mode == 1) ? cyc[0] : 1'b0);
    DATA_VALID_IN = dv;
    DATA_IN       = d;
    FRAME_READY   = rdy;
    if (dv) last_dv = cyc;
    if (FRAME_VALID === 1'b1 && rdy) begin
      bq.push_back(FRAME_DATA);
      lq.push_back(FRAME_LAST);
    end
    p_stall = (FRAME_VALID === 1'b1) && !rdy;
    p_data  = FRAME_DATA;
    p_last  = FRAME_LAST;
  endtask

  task automatic feed(input logic [15:0] d, input int gap);
    step(1'b1, d);
    repeat (gap - 1) step(1'b0, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h8000);
  endtask

  task automatic clear_obs();
    bq.delete();
    lq.delete();
    first_valid = -1;
    stall_viol = 0;
    stall_seen = 0;
    p_stall = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    EN = 1'b1;
    idle(3);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b1; THRESHOLD = 15'd1000;
    repeat (4) step(1'b1, 16'd40000);
    vecs++; if (FRAME_VALID !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b expected 0", FRAME_VALID); end
    vecs++; if (FRAME_DATA !== 16'd0) begin errs++; $display("FAIL reset_data: got %0d expected 0", FRAME_DATA); end
    vecs++; if (FRAME_LAST !== 1'b0) begin errs++; $display("FAIL reset_last: got %b expected 0", FRAME_LAST); end
    vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    vecs++; if (FRAME_CNT !== 16'd0) begin errs++; $display("FAIL reset_frame_cnt: got %0d expected 0", FRAME_CNT); end
    vecs++; if (DROPPED !== 8'd0) begin errs++; $display("FAIL reset_dropped: got %0d expected 0", DROPPED); end
    RST = 1'b0;
    clear_obs();
    repeat (6) step(1'b1, 16'd40000);
    vecs++; if (first_valid >= 0) begin errs++; $display("FAIL reset_no_frame: valid seen at cycle %0d expected none", first_valid); end
  endtask

  task automatic test_basic();
    int t_last;
    logic [15:0] exp;
    do_reset(); clear_obs();
    rdy_mode = 0; THRESHOLD = 15'd1000; EN = 1'b1;
    idle(2);
    t_last = 0;
    for (int i = 0; i < 34; i++) begin
      feed((i == 10) ? 16'd34000 : 16'd32768, 16);
      if (i == 33) t_last = last_dv;
    end
    for (int i = 34; i < 38; i++) feed(16'd32768, 16);
    vecs++; if (bq.size() != 32) begin errs++; $display("FAIL basic_beats: got %0d beats expected 32", bq.size()); end
    for (int j = 0; j < 32 && j < bq.size(); j++) begin
      exp = (j == 8) ? 16'd34000 : 16'd32768;
      vecs++; if (bq[j] !== exp) begin errs++; $display("FAIL basic_data[%0d]: got %0d expected %0d", j, bq[j], exp); end
      vecs++; if (lq[j] !== (j == 31)) begin errs++; $display("FAIL basic_last[%0d]: got %b expected %b", j, lq[j], (j == 31)); end
    end
    vecs++; if (first_valid != t_last + 2) begin errs++; $display("FAIL basic_latency: valid at %0d expected %0d", first_valid, t_last + 2); end
    vecs++; if (FRAME_CNT !== 16'd1) begin errs++; $display("FAIL basic_frame_cnt: got %0d expected 1", FRAME_CNT); end
    vecs++; if (DROPPED !== 8'd2) begin errs++; $display("FAIL basic_dropped: got %0d expected 2", DROPPED); end
    vecs++; if (FRAME_VALID !== 1'b0) begin errs++; $display("FAIL basic_valid_end: got %b expected 0", FRAME_VALID); end
  endtask

  task automatic test_fill_ignore();
    do_reset(); clear_obs();
    rdy_mode = 0; THRESHOLD = 15'd1000; EN = 1'b1;
    idle(2);
    for (int i = 0; i < 12; i++) feed((i == 3) ? 16'd40000 : 16'd32768, 4);
    vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL fill_busy: got %b expected 0", BUSY); end
    vecs++; if (first_valid >= 0) begin errs++; $display("FAIL fill_no_frame: valid at %0d expected none", first_valid); end
    feed(16'd40000, 2);
    vecs++; if (BUSY !== 1'b1) begin errs++; $display("FAIL fill_armed_trigger: got %b expected 1", BUSY); end
  endtask

  task automatic test_threshold();
    do_reset(); clear_obs();
    rdy_mode = 0; THRESHOLD = 15'd1000; EN = 1'b1;
    idle(2);
    for (int i = 0; i < 8; i++) feed(16'd32768, 2);
    feed(16'd33768, 2);
    for (int i = 0; i < 3; i++) feed(16'd32768, 2);
    vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL thr_equal_no_trig: got %b expected 0", BUSY); end
    feed(16'd31767, 2);
    vecs++; if (BUSY !== 1'b1) begin errs++; $display("FAIL thr_above_trig: got %b expected 1", BUSY); end
    for (int i = 0; i < 23; i++) feed(16'd32768, 2);
    idle(40);
    vecs++; if (bq.size() != 32) begin errs++; $display("FAIL thr_beats: got %0d expected 32", bq.size()); end
    if (bq.size() == 32) begin
      vecs++; if (bq[0] !== 16'd32768) begin errs++; $display("FAIL thr_beat0: got %0d expected 32768", bq[0]); end
      vecs++; if (bq[4] !== 16'd33768) begin errs++; $display("FAIL thr_beat4: got %0d expected 33768", bq[4]); end
      vecs++; if (bq[8] !== 16'd31767) begin errs++; $display("FAIL thr_beat8: got %0d expected 31767", bq[8]); end
      vecs++; if (lq[31] !== 1'b1) begin errs++; $display("FAIL thr_last: got %b expected 1", lq[31]); end
    end
    vecs++; if (FRAME_CNT !== 16'd1) begin errs++; $display("FAIL thr_frame_cnt: got %0d expected 1", FRAME_CNT); end
  endtask

  task automatic test_extremes();
    do_reset(); clear_obs();
    rdy_mode = 0; THRESHOLD = 15'h7FFF; EN = 1'b1;
    idle(2);
    for (int i = 0; i < 8; i++) feed(16'd32768, 2);
    feed(16'd65535, 2);
    vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL ext_max_no_trig: got %b expected 0", BUSY); end
    feed(16'd0, 2);
    vecs++; if (BUSY !== 1'b1) begin errs++; $display("FAIL ext_zero_trig: got %b expected 1", BUSY); end
    for (int i = 0; i < 23; i++) feed(16'd32768, 2);
    idle(40);
    vecs++; if (bq.size() != 32) begin errs++; $display("FAIL ext_beats: got %0d expected 32", bq.size()); end
    if (bq.size() == 32) begin
      vecs++; if (bq[7] !== 16'd65535) begin errs++; $display("FAIL ext_beat7: got %0d expected 65535", bq[7]); end
      vecs++; if (bq[8] !== 16'd0) begin errs++; $display("FAIL ext_beat8: got %0d expected 0", bq[8]); end
    end
  endtask

  task automatic test_stall();
    logic [15:0] exp;
    do_reset(); clear_obs();
    rdy_mode = 1; THRESHOLD = 15'd1000; EN = 1'b1;
    idle(2);
    for (int i = 0; i < 32; i++) feed((i == 8) ? 16'd40000 : 16'(32768 + i), 4);
    for (int i = 0; i < 20; i++) feed(16'd32768, 4);
    vecs++; if (bq.size() != 32) begin errs++; $display("FAIL stall_beats: got %0d expected 32", bq.size()); end
    for (int j = 0; j < 32 && j < bq.size(); j++) begin
      exp = (j == 8) ? 16'd40000 : 16'(32768 + j);
      vecs++; if (bq[j] !== exp) begin errs++; $display("FAIL stall_data[%0d]: got %0d expected %0d", j, bq[j], exp); end
      vecs++; if (lq[j] !== (j == 31)) begin errs++; $display("FAIL stall_last[%0d]: got %b expected %b", j, lq[j], (j == 31)); end
    end
    vecs++; if (stall_seen == 0) begin errs++; $display("FAIL stall_seen: got 0 stalled cycles expected >0"); end
    vecs++; if (stall_viol != 0) begin errs++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", stall_viol); end
    vecs++; if (DROPPED !== 8'd16) begin errs++; $display("FAIL stall_dropped: got %0d expected 16", DROPPED); end
    vecs++; if (FRAME_CNT !== 16'd1) begin errs++; $display("FAIL stall_frame_cnt: got %0d expected 1", FRAME_CNT); end
  endtask

  // Runs straight after test_stall: FRAME_CNT=1 and DROPPED=16 must survive.
  task automatic test_en_abort();
    clear_obs();
    rdy_mode = 0; THRESHOLD = 15'd1000;
    EN = 1'b0; idle(2);
    EN = 1'b1; idle(1);
    for (int i = 0; i < 8; i++) feed(16'd32768, 2);
    feed(16'd40000, 2);
    vecs++; if (BUSY !== 1'b1) begin errs++; $display("FAIL abort_capture: got %b expected 1", BUSY); end
    for (int i = 0; i < 4; i++) feed(16'd32768, 2);
    EN = 1'b0;
    for (int i = 0; i < 5; i++) feed(16'd32768, 1);
    vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL abort_busy: got %b expected 0", BUSY); end
    vecs++; if (first_valid >= 0) begin errs++; $display("FAIL abort_no_frame: valid at %0d expected none", first_valid); end
    vecs++; if (FRAME_CNT !== 16'd1) begin errs++; $display("FAIL abort_frame_cnt: got %0d expected 1", FRAME_CNT); end
    vecs++; if (DROPPED !== 8'd16) begin errs++; $display("FAIL abort_dropped: got %0d expected 16", DROPPED); end
    EN = 1'b1; idle(1);
    for (int i = 0; i < 8; i++) feed((i == 3) ? 16'd40000 : 16'd32768, 2);
    vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL abort_refill: got %b expected 0", BUSY); end
    feed(16'd40000, 2);
    vecs++; if (BUSY !== 1'b1) begin errs++; $display("FAIL abort_rearm: got %b expected 1", BUSY); end
    for (int i = 0; i < 23; i++) feed(16'd32768, 2);
    rdy_mode = 2;
    idle(4);
    vecs++; if (FRAME_VALID !== 1'b1) begin errs++; $display("FAIL abort_send_valid: got %b expected 1", FRAME_VALID); end
    EN = 1'b0;
    idle(1);
    vecs++; if (FRAME_VALID !== 1'b0) begin errs++; $display("FAIL abort_send_valid_drop: got %b expected 0", FRAME_VALID); end
    vecs++; if (FRAME_LAST !== 1'b0) begin errs++; $display("FAIL abort_send_last: got %b expected 0", FRAME_LAST); end
    vecs++; if (BUSY !== 1'b0) begin errs++; $display("FAIL abort_send_busy: got %b expected 0", BUSY); end
    vecs++; if (FRAME_CNT !== 16'd1) begin errs++; $display("FAIL abort_send_cnt: got %0d expected 1", FRAME_CNT); end
    vecs++; if (bq.size() != 0) begin errs++; $display("FAIL abort_send_beats: got %0d expected 0", bq.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_ignore();
    test_threshold();
    test_extremes();
    test_stall();
    test_en_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/spike_frame_extractor.md
SPIKE_FRAME_EXTRACTOR -- requirements
Module: spike_frame_extractor

Interface
REQ-001 SHALL have parameter BITSIZE, default 16, sample width in bits, offset-binary.
REQ-002 SHALL have parameter PRE, default 8, number of pre-trigger samples per frame.
REQ-003 SHALL have parameter POST, default 24, number of samples from the trigger sample onwards; FRAME = PRE+POST SHALL be a power of two.
REQ-004 SHALL have CLK  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have EN  input  1  block enable.
REQ-007 SHALL have DATA_IN  input  BITSIZE  filtered sample from the upstream FIR stage.
REQ-008 SHALL have DATA_VALID_IN  input  1  one-cycle strobe marking DATA_IN valid (upstream DATA_VALID).
REQ-009 SHALL have THRESHOLD  input  BITSIZE-1  unsigned detection threshold on |sample - MID|, MID = 2^(BITSIZE-1).
REQ-010 SHALL have FRAME_DATA  output  BITSIZE  frame sample, oldest first.
REQ-011 SHALL have FRAME_VALID  output  1  FRAME_DATA valid.
REQ-012 SHALL have FRAME_READY  input  1  downstream accepts beat when FRAME_VALID and FRAME_READY high.
REQ-013 SHALL have FRAME_LAST  output  1  high with the final (FRAME-th) beat.
REQ-014 SHALL have BUSY  output  1  high in CAPTURE or SEND.
REQ-015 SHALL have FRAME_CNT  output  16  completed frames, wraps at 65535->0.
REQ-016 SHALL have DROPPED  output  8  samples ignored during SEND, saturates at 255.

Function
REQ-017 SHALL keep a FRAME-deep ring buffer; each DATA_VALID_IN while EN high in FILL, ARMED or CAPTURE writes DATA_IN and advances the write pointer modulo FRAME.
REQ-018 SHALL implement FSM states IDLE, FILL, ARMED, CAPTURE, SEND.
REQ-019 IDLE->FILL when EN high; fill counter cleared on entry to FILL.
REQ-020 FILL->ARMED once PRE samples have been written since FILL entry; no trigger evaluated in FILL.
REQ-021 ARMED->CAPTURE on a written sample with |DATA_IN - MID| strictly greater than THRESHOLD (both polarities); that sample is post-sample 1.
REQ-022 CAPTURE->SEND after POST-1 further samples written; the buffer then holds exactly the frame, oldest entry at the write pointer.
REQ-023 In SEND, FRAME beats SHALL be output in write order; ring-buffer read registered; FRAME_VALID first high exactly 2 cycles after the DATA_VALID_IN cycle of the last sample.
REQ-024 While FRAME_VALID high and FRAME_READY low, FRAME_DATA and FRAME_LAST SHALL hold stable.
REQ-025 On the accepted FRAME_LAST beat: FRAME_VALID low next cycle, FRAME_CNT increments, state ->FILL (fresh PRE samples required before re-arm).
REQ-026 DATA_VALID_IN during SEND SHALL not write the buffer and SHALL increment DROPPED.
REQ-027 EN low in any state SHALL force IDLE next cycle, discarding any partial frame; FRAME_VALID, FRAME_LAST deasserted even mid-frame; FRAME_CNT, DROPPED retained.
REQ-028 Absolute deviation SHALL be computed at BITSIZE+1 bits without overflow; DATA_IN = 0 gives deviation 2^(BITSIZE-1).

Reset
REQ-029 RST high SHALL, on the next edge, set state IDLE, pointers, fill counter, FRAME_CNT, DROPPED to 0, FRAME_DATA 0, FRAME_VALID, FRAME_LAST, BUSY low; RST dominates EN.
REQ-030 Buffer contents need not be reset; no stale entry SHALL be output, guaranteed by REQ-020/022.

Verification
REQ-031 RST high 3 cycles with EN high -> all outputs 0, BUSY low, no FRAME_VALID until a full frame is captured.
REQ-032 THRESHOLD=1000, samples 32768 x10 then 34000 at index 10, then 32768, strobe every 16 cycles, READY=1 -> 32 beats = sample indices 2..33, beat 9 = 34000, FRAME_LAST on beat 32, FRAME_CNT=1.
REQ-033 Spike 40000 at sample index 3 after enable -> ignored (FILL), no frame.
REQ-034 Sample 33768 (deviation exactly 1000) -> no trigger; sample 31767 (deviation 1001) -> trigger.
REQ-035 FRAME_READY toggling 1,0 each cycle during SEND -> all 32 beats in order, data stable while stalled; strobes during SEND counted in DROPPED.
REQ-036 EN low during CAPTURE for 5 cycles -> no FRAME_VALID; after EN high, PRE new samples required before a spike triggers.
